aes_encrypt_sequencer: RTL and testbench

Control block for one AES-128 encryption pass. It accepts a plaintext/key pair over a valid/ready handshake and starts the existing round-key expansion block. It waits out the fixed expansion latency, then steps an external single-cycle round datapath through rounds 1..10 using the selected round key. It owns the 128-bit cipher state register and returns the ciphertext over a second valid/ready handshake.

---
 rtl/aes_encrypt_sequencer.sv | 174 +++++++++++++++++
 tb/tb_aes_encrypt_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_sequencer.sv
// AES-128 encryption sequencer: accepts plaintext/key, starts key expansion, steps an
// external round datapath through NUM_ROUNDS rounds, returns ciphertext. Option: KEY_CACHE_EN.
module aes_encrypt_sequencer #(
  parameter int NUM_ROUNDS  = 10,
  parameter int KEY_LATENCY = 3,
  parameter int ROUND_W     = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       data_in,
  input  logic [127:0]       key_in,
  output logic               kc_start,
  output logic [127:0]       kc_key,
  output logic [ROUND_W-1:0] rk_sel,
  output logic               rnd_en,
  output logic               rnd_last,
  output logic [127:0]       rnd_state,
  input  logic [127:0]       rnd_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       data_out,
  output logic               busy,
  output logic [15:0]        blk_count
);

  localparam int CNT_W = (KEY_LATENCY < 1) ? 1 : $clog2(KEY_LATENCY + 1);
  localparam logic [CNT_W-1:0]   GUARD_INIT = CNT_W'(KEY_LATENCY);
  localparam logic [CNT_W-1:0]   WAIT_INIT  = CNT_W'(KEY_LATENCY - 1);
  localparam logic [ROUND_W-1:0] RND_FIRST  = ROUND_W'(1);
  localparam logic [ROUND_W-1:0] RND_LAST   = ROUND_W'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    S_GUARD,
    S_IDLE,
    S_KEY_WAIT,
    S_ROUND,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 in_ready_q;
  logic                 kc_start_q;
  logic [127:0]         kc_key_q;
  logic [ROUND_W-1:0]   rk_sel_q;
  logic                 rnd_en_q;
  logic                 rnd_last_q;
  logic [127:0]         rnd_state_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic [15:0]          blk_count_q;

  logic [CNT_W-1:0]     cnt_d;
  logic [ROUND_W-1:0]   round_d;
  logic                 skip_kw_d;

`ifdef KEY_CACHE_EN
  logic cache_vld_q;
`endif

  always_comb begin
    cnt_d   = cnt_q - CNT_W'(1);
    round_d = rk_sel_q + RND_FIRST;
`ifdef KEY_CACHE_EN
    skip_kw_d = cache_vld_q && (key_in == kc_key_q);
`else
    skip_kw_d = 1'b0;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_GUARD;
      cnt_q       <= GUARD_INIT;
      in_ready_q  <= 1'b0;
      kc_start_q  <= 1'b0;
      kc_key_q    <= '0;
      rk_sel_q    <= '0;
      rnd_en_q    <= 1'b0;
      rnd_last_q  <= 1'b0;
      rnd_state_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      blk_count_q <= '0;
`ifdef KEY_CACHE_EN
      cache_vld_q <= 1'b0;
`endif
    end else begin
      kc_start_q <= 1'b0;
      case (state_q)
        // Give an unreset key expander time to drain before the first start pulse.
        S_GUARD: begin
          if (cnt_q == '0) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            cnt_q  <= cnt_d;
            busy_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            rnd_state_q <= data_in ^ key_in;
            kc_key_q    <= key_in;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            if (skip_kw_d) begin
              state_q    <= S_ROUND;
              rk_sel_q   <= RND_FIRST;
              rnd_en_q   <= 1'b1;
              rnd_last_q <= (RND_FIRST == RND_LAST);
            end else begin
              state_q    <= S_KEY_WAIT;
              kc_start_q <= 1'b1;
              cnt_q      <= WAIT_INIT;
            end
          end
        end
        S_KEY_WAIT: begin
          if (cnt_q == '0) begin
            state_q    <= S_ROUND;
            rk_sel_q   <= RND_FIRST;
            rnd_en_q   <= 1'b1;
            rnd_last_q <= (RND_FIRST == RND_LAST);
`ifdef KEY_CACHE_EN
            cache_vld_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_ROUND: begin
          rnd_state_q <= rnd_result;
          if (rk_sel_q == RND_LAST) begin
            state_q     <= S_DONE;
            rk_sel_q    <= '0;
            rnd_en_q    <= 1'b0;
            rnd_last_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            rk_sel_q   <= round_d;
            rnd_last_q <= (round_d == RND_LAST);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            blk_count_q <= blk_count_q + 16'd1;
          end
        end
        default: state_q <= S_GUARD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign kc_start  = kc_start_q;
  assign kc_key    = kc_key_q;
  assign rk_sel    = rk_sel_q;
  assign rnd_en    = rnd_en_q;
  assign rnd_last  = rnd_last_q;
  assign rnd_state = rnd_state_q;
  assign out_valid = out_valid_q;
  assign data_out  = rnd_state_q;
  assign busy      = busy_q;
  assign blk_count = blk_count_q;

endmodule

// File: tb/tb_aes_encrypt_sequencer.sv
// Self-checking bench for aes_encrypt_sequencer: behavioural AES-128 model supplies the
// round datapath and the expected ciphertexts; define KEY_CACHE_EN to match a cached build.
module tb_aes_encrypt_sequencer;

  localparam int NR = 10;
  localparam int KL = 3;
  localparam int RW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  data_in = '0;
  logic [127:0]  key_in = '0;
  logic          kc_start;
  logic [127:0]  kc_key;
  logic [RW-1:0] rk_sel;
  logic          rnd_en;
  logic          rnd_last;
  logic [127:0]  rnd_state;
  logic [127:0]  rnd_result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [127:0]  data_out;
  logic          busy;
  logic [15:0]   blk_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_blk  = 0;

  logic [7:0]    sbox [0:255];
  logic [RW-1:0] obs_rk   [0:63];
  logic          obs_en   [0:63];
  logic          obs_last [0:63];

  always #5 clock = ~clock;

  aes_encrypt_sequencer #(.NUM_ROUNDS(NR), .KEY_LATENCY(KL), .ROUND_W(RW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .key_in(key_in), .kc_start(kc_start), .kc_key(kc_key),
    .rk_sel(rk_sel), .rnd_en(rnd_en), .rnd_last(rnd_last), .rnd_state(rnd_state),
    .rnd_result(rnd_result), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .busy(busy), .blk_count(blk_count)
  );

  // ---------------- AES-128 reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] ex [0:255];
    logic [7:0] lg [0:255];
    logic [7:0] p, inv;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = 8'(i);
      p = p ^ xt(p);
    end
    for (int x = 0; x < 256; x++) begin
      if (x == 0) inv = 8'h00;
      else inv = ex[(255 - int'(lg[x])) % 255];
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[c*4+r] = sbox[s[127-8*((((c+r)%4)*4)+r) -: 8]];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
        t[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ rk;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    if (r < 0 || r > NR) return '0;
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s;
    s = pt ^ key;
    for (int r = 1; r <= NR; r++) s = aes_round(s, round_key(key, r), r == NR);
    return s;
  endfunction

  // Environment: key expander plus single-cycle round datapath.
  assign rnd_result = aes_round(rnd_state, round_key(kc_key, int'(rk_sel)), rnd_last);

  // ---------------- stimulus helper (no checking) ----------------
  task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input bit consume,
                           output int wait_n, output int lat, output int kc_n,
                           output logic [127:0] ct);
    in_valid = 1'b1; data_in = pt; key_in = key;
    wait_n = 0;
    while (!in_ready && wait_n < 100) begin @(negedge clock); wait_n++; end
    @(negedge clock);
    in_valid = 1'b0; data_in = {4{$urandom}}; key_in = {4{$urandom}};
    lat = 1; kc_n = 0;
    while (!out_valid && lat < 100) begin
      if (kc_start) kc_n++;
      if (lat < 64) begin obs_rk[lat] = rk_sel; obs_en[lat] = rnd_en; obs_last[lat] = rnd_last; end
      @(negedge clock);
      lat++;
    end
    ct = data_out;
    if (consume) begin out_ready = 1'b1; @(negedge clock); out_ready = 1'b0; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({in_ready, kc_start, rnd_en, rnd_last, out_valid, busy} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000",
                         {in_ready, kc_start, rnd_en, rnd_last, out_valid, busy});
    end
    n_checks++;
    if (rk_sel !== '0 || blk_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counts: rk_sel %0d blk_count %0d want 0 0", rk_sel, blk_count);
    end
    n_checks++;
    if (kc_key !== '0 || rnd_state !== '0) begin
      n_fail++; $display("FAIL reset_regs: kc_key %h rnd_state %h want 0", kc_key, rnd_state);
    end
  endtask

  task automatic test_guard_fips();
    int wait_n, lat, kc_n, bad;
    logic [127:0] ct;
    logic [127:0] key = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] pt  = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] fips_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    reset = 1'b0;
    run_block(pt, key, 1'b1, wait_n, lat, kc_n, ct);
    exp_blk++;
    n_checks++;
    if (wait_n !== KL + 1) begin n_fail++; $display("FAIL guard_len: got %0d want %0d", wait_n, KL + 1); end
    n_checks++;
    if (lat !== 1 + KL + NR) begin n_fail++; $display("FAIL fips_latency: got %0d want %0d", lat, 1 + KL + NR); end
    n_checks++;
    if (kc_n !== 1) begin n_fail++; $display("FAIL fips_kc_start: got %0d pulses want 1", kc_n); end
    n_checks++;
    if (ct !== fips_ct) begin n_fail++; $display("FAIL fips_ct: got %h want %h", ct, fips_ct); end
    n_checks++;
    if (aes_encrypt(pt, key) !== fips_ct) begin
      n_fail++; $display("FAIL fips_model: got %h want %h", aes_encrypt(pt, key), fips_ct);
    end
    n_checks++;
    if (blk_count !== 16'(exp_blk) || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL fips_after: blk %0d rdy %b ov %b want %0d 1 0", blk_count, in_ready, out_valid, exp_blk);
    end
    bad = 0;
    for (int k = 1; k < 1 + KL + NR && k < 64; k++) begin
      if (obs_en[k] !== (k >= 1 + KL)) bad++;
      if (obs_rk[k] !== ((k >= 1 + KL) ? RW'(k - KL) : RW'(0))) bad++;
      if (obs_last[k] !== (k == KL + NR)) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL round_ctrl: got %0d bad samples want 0", bad); end
  endtask

  task automatic test_random();
    int wait_n, lat, kc_n, d;
    logic [127:0] ct, pt, key;
    for (int it = 0; it < 5; it++) begin
      pt = {4{$urandom}}; key = {4{$urandom}};
      run_block(pt, key, 1'b0, wait_n, lat, kc_n, ct);
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clock);
      out_ready = 1'b1; @(negedge clock); out_ready = 1'b0;
      exp_blk++;
      n_checks++;
      if (ct !== aes_encrypt(pt, key) || lat !== 1 + KL + NR || kc_n !== 1) begin
        n_fail++; $display("FAIL random_block%0d: ct %h lat %0d kc %0d want %h %0d 1",
                           it, ct, lat, kc_n, aes_encrypt(pt, key), 1 + KL + NR);
      end
      n_checks++;
      if (blk_count !== 16'(exp_blk)) begin
        n_fail++; $display("FAIL random_count%0d: got %0d want %0d", it, blk_count, exp_blk);
      end
    end
  endtask

  task automatic test_back_to_back();
    int wait_n, lat, kc_n, exp_lat, exp_kc;
    logic [127:0] ct, pt1, pt2, key;
`ifdef KEY_CACHE_EN
    exp_lat = 1 + NR; exp_kc = 0;
`else
    exp_lat = 1 + KL + NR; exp_kc = 1;
`endif
    key = {4{$urandom}}; pt1 = {4{$urandom}}; pt2 = {4{$urandom}};
    run_block(pt1, key, 1'b1, wait_n, lat, kc_n, ct);
    exp_blk++;
    n_checks++;
    if (ct !== aes_encrypt(pt1, key) || kc_n !== 1) begin
      n_fail++; $display("FAIL b2b_first: ct %h kc %0d want %h 1", ct, kc_n, aes_encrypt(pt1, key));
    end
    run_block(pt2, key, 1'b1, wait_n, lat, kc_n, ct);
    exp_blk++;
    n_checks++;
    if (wait_n !== 0) begin n_fail++; $display("FAIL b2b_ready: waited %0d want 0", wait_n); end
    n_checks++;
    if (lat !== exp_lat || kc_n !== exp_kc) begin
      n_fail++; $display("FAIL b2b_second: lat %0d kc %0d want %0d %0d", lat, kc_n, exp_lat, exp_kc);
    end
    n_checks++;
    if (ct !== aes_encrypt(pt2, key) || blk_count !== 16'(exp_blk)) begin
      n_fail++; $display("FAIL b2b_ct: ct %h blk %0d want %h %0d", ct, blk_count, aes_encrypt(pt2, key), exp_blk);
    end
  endtask

  task automatic test_done_hold();
    int wait_n, lat, kc_n;
    logic [127:0] ct, pt, key;
    logic [15:0] bc;
    pt = {4{$urandom}}; key = {4{$urandom}};
    run_block(pt, key, 1'b0, wait_n, lat, kc_n, ct);
    bc = blk_count;
    n_checks++;
    if (ct !== aes_encrypt(pt, key)) begin n_fail++; $display("FAIL hold_ct: got %h want %h", ct, aes_encrypt(pt, key)); end
    in_valid = 1'b1; data_in = {4{$urandom}}; key_in = {4{$urandom}};
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      n_checks++;
      if (out_valid !== 1'b1 || data_out !== ct || in_ready !== 1'b0 || blk_count !== bc || busy !== 1'b1) begin
        n_fail++; $display("FAIL hold_cycle%0d: ov %b data %h rdy %b blk %0d busy %b want 1 %h 0 %0d 1",
                           c, out_valid, data_out, in_ready, blk_count, busy, ct, bc);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1; @(negedge clock); out_ready = 1'b0;
    exp_blk++;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || blk_count !== 16'(exp_blk) || busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: ov %b rdy %b blk %0d busy %b want 0 1 %0d 0",
                         out_valid, in_ready, blk_count, busy, exp_blk);
    end
  endtask

  task automatic test_reset_mid();
    int n, wait_n, lat, kc_n;
    bit ov_seen;
    logic [127:0] ct, pt, key;
    in_valid = 1'b1; data_in = {4{$urandom}}; key_in = {4{$urandom}};
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clock); n++; end
    @(negedge clock);
    in_valid = 1'b0;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || blk_count !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || rnd_en !== 1'b0) begin
      n_fail++; $display("FAIL midreset_now: busy %b blk %0d ov %b rdy %b en %b want 0 0 0 0 0",
                         busy, blk_count, out_valid, in_ready, rnd_en);
    end
    exp_blk = 0;
    @(negedge clock);
    reset = 1'b0;
    n = 0; ov_seen = 1'b0;
    while (!in_ready && n < 50) begin
      if (out_valid) ov_seen = 1'b1;
      @(negedge clock); n++;
    end
    repeat (15) begin if (out_valid) ov_seen = 1'b1; @(negedge clock); end
    n_checks++;
    if (n !== KL + 1 || ov_seen) begin
      n_fail++; $display("FAIL midreset_guard: guard %0d out_valid_seen %b want %0d 0", n, ov_seen, KL + 1);
    end
    pt = {4{$urandom}}; key = {4{$urandom}};
    run_block(pt, key, 1'b1, wait_n, lat, kc_n, ct);
    exp_blk++;
    n_checks++;
    if (ct !== aes_encrypt(pt, key) || blk_count !== 16'(exp_blk)) begin
      n_fail++; $display("FAIL midreset_recover: ct %h blk %0d want %h %0d", ct, blk_count, aes_encrypt(pt, key), exp_blk);
    end
  endtask

  task automatic test_wrap();
    int wait_n, lat, kc_n;
    logic [127:0] ct, pt, key;
    force dut.blk_count_q = 16'hFFFF;
    @(negedge clock);
    release dut.blk_count_q;
    @(negedge clock);
    n_checks++;
    if (blk_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", blk_count); end
    pt = {4{$urandom}}; key = {4{$urandom}};
    run_block(pt, key, 1'b1, wait_n, lat, kc_n, ct);
    n_checks++;
    if (blk_count !== 16'h0000 || ct !== aes_encrypt(pt, key)) begin
      n_fail++; $display("FAIL wrap_count: blk %h ct %h want 0000 %h", blk_count, ct, aes_encrypt(pt, key));
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_guard_fips();
    test_random();
    test_back_to_back();
    test_done_hold();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
